// File: rtl/bram_sdp.sv
// rtl/bram_sdp.sv - simple dual-port RAM: synchronous write, registered read
module bram_sdp #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 256,
  parameter int ADDRW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [ADDRW-1:0] waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [ADDRW-1:0] raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  // Read and write share one block, so a same-address collision returns the old word.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
    rdata <= mem[raddr];
  end

endmodule

// File: rtl/rom_loader.sv
// rtl/rom_loader.sv - fills a word memory from a byte stream, exposes a ROM-style read port
module rom_loader #(
  parameter  int WIDTH  = 8,
  parameter  int DEPTH  = 256,
  localparam int ADDRW  = $clog2(DEPTH),
  localparam int NBYTES = WIDTH / 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [7:0]       din,
  input  logic             din_valid,
  output logic             din_ready,
  output logic             busy,
  output logic             done,
  output logic [ADDRW:0]   count,
  input  logic [ADDRW-1:0] rd_addr,
  output logic [WIDTH-1:0] rd_data
);

  localparam int IDXW = (NBYTES > 1) ? $clog2(NBYTES) : 1;

  if (WIDTH % 8 != 0 || WIDTH < 8) begin : g_width_check
    $error("rom_loader: WIDTH must be a nonzero multiple of 8");
  end

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    DONE
  } state_t;

  state_t            state;
  logic [IDXW-1:0]   byte_idx;
  logic [ADDRW-1:0]  waddr;
  logic [WIDTH-1:0]  pack;
  logic [WIDTH-1:0]  next_word;
  logic              last_byte;
  logic              we;

  // Shifting left byte by byte leaves the first byte in the MS position once the word is full.
  assign next_word = (pack << 8) | WIDTH'(din);
  assign last_byte = (byte_idx == IDXW'(NBYTES - 1));
  assign we        = (state == LOAD) && din_valid && last_byte;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      din_ready <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      count     <= '0;
      byte_idx  <= '0;
      waddr     <= '0;
      pack      <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state     <= LOAD;
            din_ready <= 1'b1;
            busy      <= 1'b1;
            waddr     <= '0;
            byte_idx  <= '0;
            count     <= '0;
          end
        end
        LOAD: begin
          if (din_valid) begin
            pack <= next_word;
            if (last_byte) begin
              byte_idx <= '0;
              waddr    <= waddr + ADDRW'(1);
              count    <= count + (ADDRW + 1)'(1);
              if (waddr == ADDRW'(DEPTH - 1)) begin
                state     <= DONE;
                din_ready <= 1'b0;
                busy      <= 1'b0;
                done      <= 1'b1;
              end
            end else begin
              byte_idx <= byte_idx + IDXW'(1);
            end
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  bram_sdp #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .ADDRW (ADDRW)
  ) u_mem (
    .clk   (clk),
    .we    (we),
    .waddr (waddr),
    .wdata (next_word),
    .raddr (rd_addr),
    .rdata (rd_data)
  );

endmodule

// File: tb/tb_rom_loader.sv
// tb/tb_rom_loader.sv - scoreboard bench for rom_loader (16x4 and 8x256 instances)
module tb_rom_loader;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int  total = 0;
  int  bad   = 0;
  bit  mon_on = 1'b0;

  typedef struct {
    int          due;
    logic [15:0] val;
  } rd_t;

  // DUT A: WIDTH=16, DEPTH=4
  logic        a_rst, a_start, a_valid, a_ready, a_busy, a_done;
  logic [7:0]  a_din;
  logic [2:0]  a_count;
  logic [1:0]  a_rd_addr;
  logic [15:0] a_rd_data;

  // DUT B: WIDTH=8, DEPTH=256
  logic        b_rst, b_start, b_valid, b_ready, b_busy, b_done;
  logic [7:0]  b_din;
  logic [8:0]  b_count;
  logic [7:0]  b_rd_addr;
  logic [7:0]  b_rd_data;

  rom_loader #(.WIDTH(16), .DEPTH(4)) u_a (
    .clk(clk), .rst(a_rst), .start(a_start), .din(a_din), .din_valid(a_valid),
    .din_ready(a_ready), .busy(a_busy), .done(a_done), .count(a_count),
    .rd_addr(a_rd_addr), .rd_data(a_rd_data)
  );

  rom_loader #(.WIDTH(8), .DEPTH(256)) u_b (
    .clk(clk), .rst(b_rst), .start(b_start), .din(b_din), .din_valid(b_valid),
    .din_ready(b_ready), .busy(b_busy), .done(b_done), .count(b_count),
    .rd_addr(b_rd_addr), .rd_data(b_rd_data)
  );

  // Reference model A: word array plus a notion of "loading" and byte progress
  logic [15:0] ma [4];
  bit          ka [4];
  bit          a_load = 0, a_dn = 0;
  int          a_bi = 0, a_wa = 0, a_cnt = 0;
  logic [15:0] a_part = '0;
  int          a_doneq [$];
  rd_t         rda_q [$];
  int          a_last_done = -1;

  // Reference model B: one byte per word
  logic [7:0]  mb [256];
  bit          kb [256];
  bit          b_load = 0, b_dn = 0;
  int          b_wa = 0, b_cnt = 0;
  int          b_doneq [$];
  rd_t         rdb_q [$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic a_cyc(input bit st, input bit v, input logic [7:0] d, input bit rc, input int ra);
    a_start   = st;
    a_valid   = v;
    a_din     = d;
    a_rd_addr = ra[1:0];
    if (rc && ka[ra]) rda_q.push_back('{cyc + 1, ma[ra]});
    @(posedge clk);
    #1;
    if (a_dn) begin
      a_dn = 0;
    end else if (!a_load) begin
      if (st) begin
        a_load = 1; a_wa = 0; a_bi = 0; a_cnt = 0;
      end
    end else if (v) begin
      a_part = {a_part[7:0], d};
      a_bi++;
      if (a_bi == 2) begin
        ma[a_wa] = a_part;
        ka[a_wa] = 1;
        a_cnt++;
        a_bi = 0;
        if (a_wa == 3) begin
          a_load = 0;
          a_dn   = 1;
          a_doneq.push_back(cyc);
        end
        a_wa = (a_wa + 1) % 4;
      end
    end
  endtask

  task automatic a_reset();
    a_rst = 1; a_start = 0; a_valid = 0;
    a_load = 0; a_dn = 0; a_cnt = 0; a_bi = 0; a_wa = 0;
    a_doneq.delete();
    @(posedge clk);
    #1;
    a_rst = 0;
  endtask

  task automatic b_cyc(input bit st, input bit v, input logic [7:0] d, input bit rc, input int ra);
    b_start   = st;
    b_valid   = v;
    b_din     = d;
    b_rd_addr = ra[7:0];
    if (rc && kb[ra]) rdb_q.push_back('{cyc + 1, {8'h00, mb[ra]}});
    @(posedge clk);
    #1;
    if (b_dn) begin
      b_dn = 0;
    end else if (!b_load) begin
      if (st) begin
        b_load = 1; b_wa = 0; b_cnt = 0;
      end
    end else if (v) begin
      mb[b_wa] = d;
      kb[b_wa] = 1;
      b_cnt++;
      if (b_wa == 255) begin
        b_load = 0;
        b_dn   = 1;
        b_doneq.push_back(cyc);
      end
      b_wa = (b_wa + 1) % 256;
    end
  endtask

  task automatic a_read_all();
    for (int i = 0; i < 4; i++) a_cyc(0, 0, 8'h00, 1, i);
    a_cyc(0, 0, 8'h00, 0, 0);
  endtask

  task automatic a_drain(input string nm);
    int k = 0;
    while ((a_load || a_dn) && k < 200) begin
      a_cyc(0, 1, 8'($urandom), $urandom_range(0, 1), $urandom_range(0, 3));
      k++;
    end
    chk(nm, 32'(k < 200), 32'd1);
  endtask

  always @(negedge clk) begin : mon_a
    bit  exp_done;
    rd_t r;
    if (mon_on) begin
      chk("a_busy", a_busy, a_load);
      chk("a_din_ready", a_ready, a_load);
      chk("a_count", a_count, a_cnt);
      if (rda_q.size() > 0 && rda_q[0].due == cyc) begin
        r = rda_q.pop_front();
        chk("a_rd_data", a_rd_data, r.val);
      end
      exp_done = (a_doneq.size() > 0) && (a_doneq[0] == cyc);
      chk("a_done", a_done, exp_done);
      if (exp_done) void'(a_doneq.pop_front());
      if (a_done === 1'b1) a_last_done = cyc;
    end
  end

  always @(negedge clk) begin : mon_b
    bit  exp_done;
    rd_t r;
    if (mon_on) begin
      chk("b_busy", b_busy, b_load);
      chk("b_din_ready", b_ready, b_load);
      chk("b_count", b_count, b_cnt);
      if (rdb_q.size() > 0 && rdb_q[0].due == cyc) begin
        r = rdb_q.pop_front();
        chk("b_rd_data", b_rd_data, r.val);
      end
      exp_done = (b_doneq.size() > 0) && (b_doneq[0] == cyc);
      chk("b_done", b_done, exp_done);
      if (exp_done) void'(b_doneq.pop_front());
    end
  end

  initial begin
    #2000000;
    bad++;
    $display("FAIL timeout: got running want finished");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    logic [7:0] pat [8] = '{8'h12, 8'h34, 8'h56, 8'h78, 8'h9A, 8'hBC, 8'hDE, 8'hF0};
    int s1, s2, lat1, lat2;

    a_rst = 1; a_start = 0; a_valid = 0; a_din = '0; a_rd_addr = '0;
    b_rst = 1; b_start = 0; b_valid = 0; b_din = '0; b_rd_addr = '0;
    repeat (3) @(posedge clk);
    #1;
    a_rst = 0; b_rst = 0;
    mon_on = 1;

    // idle after reset: nothing moves without start
    repeat (8) a_cyc(0, $urandom_range(0, 1), 8'($urandom), 0, 0);

    // back-to-back load of the reference pattern
    a_last_done = -1;
    s1 = cyc;
    a_cyc(1, 0, 8'h00, 0, 0);
    for (int i = 0; i < 8; i++) a_cyc(0, 1, pat[i], 0, 0);
    repeat (2) a_cyc(0, 0, 8'h00, 0, 0);
    lat1 = a_last_done - s1;
    chk("lat_back_to_back", lat1, 9);
    a_read_all();

    // same pattern with din_valid toggling every cycle
    a_last_done = -1;
    s2 = cyc;
    a_cyc(1, 0, 8'h00, 0, 0);
    for (int i = 0; i < 8; i++) begin
      a_cyc(0, 1, pat[i], 0, 0);
      if (i < 7) a_cyc(0, 0, 8'($urandom), 0, 0);
    end
    repeat (2) a_cyc(0, 0, 8'h00, 0, 0);
    lat2 = a_last_done - s2;
    chk("lat_toggle_extra", lat2 - lat1, 7);
    a_read_all();

    // reset after 5 bytes: words 0,1 replaced, word 2 keeps its old value
    a_cyc(1, 0, 8'h00, 0, 0);
    for (int i = 0; i < 5; i++) a_cyc(0, 1, 8'($urandom), 0, 0);
    a_reset();
    chk("count_after_reset", a_count, 0);
    chk("busy_after_reset", a_busy, 0);
    a_read_all();
    a_cyc(1, 0, 8'h00, 0, 0);
    for (int i = 0; i < 8; i++) a_cyc(0, 1, 8'($urandom), 0, 0);
    repeat (2) a_cyc(0, 0, 8'h00, 0, 0);
    a_read_all();

    // start pulses mid-load are ignored
    a_cyc(1, 0, 8'h00, 0, 0);
    for (int i = 0; i < 3; i++) a_cyc(0, 1, 8'($urandom), 0, 0);
    a_cyc(1, 1, 8'($urandom), 0, 0);
    a_cyc(1, 0, 8'h00, 0, 0);
    for (int i = 0; i < 4; i++) a_cyc(0, 1, 8'($urandom), 0, 0);
    a_drain("start_ignored_finish");
    a_read_all();

    // randomized loads, stalls, stray starts and reads
    for (int r = 0; r < 12; r++) begin
      a_cyc(1, 0, 8'h00, 0, 0);
      for (int i = 0; i < 40; i++)
        a_cyc(($urandom_range(0, 7) == 0), $urandom_range(0, 1), 8'($urandom),
              $urandom_range(0, 1), $urandom_range(0, 3));
      if (r == 5) a_reset();
      a_drain("random_load_finish");
      a_read_all();
    end
    a_cyc(0, 0, 8'h00, 0, 0);

    // 8x256: first fill with inverted ramp, then ramp 00..FF
    b_cyc(1, 0, 8'h00, 0, 0);
    for (int i = 0; i < 256; i++) b_cyc(0, 1, 8'(255 - i), 0, 0);
    repeat (2) b_cyc(0, 0, 8'h00, 0, 0);
    b_cyc(1, 0, 8'h00, 0, 0);
    for (int i = 0; i < 256; i++)
      b_cyc(0, 1, 8'(i), 1, (i >= 250) ? 255 : $urandom_range(0, 255));
    b_cyc(0, 0, 8'h00, 1, 255);
    chk("b_count_final", b_count, 256);
    b_cyc(0, 0, 8'h00, 1, 0);
    for (int i = 0; i < 16; i++) b_cyc(0, 0, 8'h00, 1, $urandom_range(0, 255));
    repeat (3) b_cyc(0, 0, 8'h00, 0, 0);
    chk("b_count_hold", b_count, 256);

    chk("rda_q_drained", rda_q.size(), 0);
    chk("rdb_q_drained", rdb_q.size(), 0);
    chk("a_doneq_drained", a_doneq.size(), 0);
    chk("b_doneq_drained", b_doneq.size(), 0);
    mon_on = 0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
